// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, default sizes, RX FSM states and
// status-register bit positions used by the register controller.
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'b00;  // {CPOL,CPHA}
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

   localparam int RX_OVF_BIT     = 0;
   localparam int RX_FRM_ERR_BIT = 1;
   localparam int RX_BUSY_BIT    = 2;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO with registered head output; a pop on a full FIFO frees a
// slot for a push in the same cycle. Shared by the SPI RX and TX paths.
module spi_rx_fifo
   import spi_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head_data,
   output logic                          head_valid,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = ADDR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [LVL_W-1:0]  count, count_nxt, remain;
   logic              do_push, do_pop;
   logic [DATA_W-1:0] head_nxt;

   always_comb begin
      do_pop     = pop && (count != '0);
      do_push    = push && ((count != LVL_W'(FIFO_DEPTH)) || do_pop);
      rd_ptr_nxt = rd_ptr + ADDR_W'(do_pop);
      remain     = count - LVL_W'(do_pop);
      count_nxt  = remain + LVL_W'(do_push);
      head_nxt   = head_data;
      // With nothing left behind the popped entry, a concurrent push becomes the head.
      if (remain != '0)
         head_nxt = mem[rd_ptr_nxt];
      else if (do_push)
         head_nxt = push_data;
   end

   // NOTE: storage needs no reset; count and pointers alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_data  <= '0;
         head_valid <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + ADDR_W'(do_push);
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         head_data  <= head_nxt;
         head_valid <= (count_nxt != '0);
      end
   end

   assign full  = (count == LVL_W'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign level = count;

endmodule

// File: rtl/spi_rx_cntrl.sv
// SPI slave receiver: synchronises SCK/CS_N/MOSI into CLK, deserialises words
// into an RX FIFO. Define SPI_RX_LSB_FIRST_EN to shift words in LSB first.
module spi_rx_cntrl
   import spi_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          SCK,
   input  logic                          CS_N,
   input  logic                          MOSI,
   input  logic                          rx_en,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          rx_ovf,
   output logic                          rx_frm_err,
   input  logic                          clr_flags,
   output logic                          rx_busy
);

   localparam int               CNT_W       = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
   localparam logic [1:0]       SPI_MODE    = 2'(CPOL * 2 + CPHA);
   localparam bit               SAMPLE_RISE = (SPI_MODE == MODE0) || (SPI_MODE == MODE3);
   localparam logic             SCK_IDLE    = 1'(CPOL);

   logic [2:0]        sck_sync, cs_sync;
   logic [1:0]        mosi_sync;
   logic              sck_edge, cs_fall, cs_rise, mosi_bit;
   rx_state_t         state, state_nxt;
   logic              shift_en, frm_err_set;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_reg, shift_nxt;
   logic              push_q, fifo_pop, fifo_full, fifo_empty, ovf_set;

   // NOTE: every flop in this design is written with <= so all stages update from pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sck_sync  <= {3{SCK_IDLE}};
         cs_sync   <= 3'b111;
         mosi_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[1:0], SCK};
         cs_sync   <= {cs_sync[1:0], CS_N};
         mosi_sync <= {mosi_sync[0], MOSI};
      end
   end

   assign sck_edge = SAMPLE_RISE ? (sck_sync[1] & ~sck_sync[2]) : (~sck_sync[1] & sck_sync[2]);
   assign cs_fall  = ~cs_sync[1] & cs_sync[2];
   assign cs_rise  = cs_sync[1] & ~cs_sync[2];
   assign mosi_bit = mosi_sync[1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
   always_comb begin
      state_nxt   = state;
      shift_en    = 1'b0;
      frm_err_set = 1'b0;
      case (state)
         IDLE: begin
            if (rx_en && cs_fall)
               state_nxt = RECV;
         end
         RECV: begin
            if (!rx_en) begin
               state_nxt = IDLE;
            end else if (cs_rise) begin
               state_nxt   = IDLE;
               frm_err_set = (bit_cnt != '0);
            end else begin
               shift_en = sck_edge;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
`ifdef SPI_RX_LSB_FIRST_EN
      shift_nxt = {mosi_bit, shift_reg[DATA_W-1:1]};
`else
      shift_nxt = {shift_reg[DATA_W-2:0], mosi_bit};
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         push_q    <= 1'b0;
      end else begin
         push_q <= shift_en && (bit_cnt == LAST_BIT);
         if (shift_en) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
         end else if (state_nxt != RECV) begin
            bit_cnt <= '0;
         end
      end
   end

   assign fifo_pop = rx_ready && !fifo_empty;
   assign ovf_set  = push_q && fifo_full && !fifo_pop;

   // Set wins over a coincident clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_ovf     <= 1'b0;
         rx_frm_err <= 1'b0;
      end else begin
         rx_ovf     <= ovf_set | (rx_ovf & ~clr_flags);
         rx_frm_err <= frm_err_set | (rx_frm_err & ~clr_flags);
      end
   end

   assign rx_busy = (state == RECV);

   spi_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .push       (push_q),
      .push_data  (shift_reg),
      .pop        (fifo_pop),
      .head_data  (rx_data),
      .head_valid (rx_valid),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .level      (rx_level)
   );

endmodule

// File: tb/tb_spi_rx_cntrl.sv
// Directed bench for spi_rx_cntrl: one instance per SPI mode sharing the pins,
// instance 0 (mode 0) carries the FIFO, flag and reset scenarios.
`timescale 1ns/1ps
module tb_spi_rx_cntrl;

   localparam int DW = 8;
   localparam int H  = 4;   // SCK half period in CLK cycles

   logic clk = 1'b0;
   logic rst, sck, cs_n, mosi, clr_flags;
   logic en    [4];
   logic ready [4];

   logic [DW-1:0] data_o  [4];
   logic          valid_o [4];
   logic [2:0]    lvl_o   [4];
   logic          ovf_o   [4];
   logic          frm_o   [4];
   logic          busy_o  [4];

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] got_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_rx_cntrl #(
         .DATA_W     (DW),
         .FIFO_DEPTH (4),
         .CPOL       (g / 2),
         .CPHA       (g % 2)
      ) u_dut (
         .CLK        (clk),
         .RST        (rst),
         .SCK        (sck),
         .CS_N       (cs_n),
         .MOSI       (mosi),
         .rx_en      (en[g]),
         .rx_data    (data_o[g]),
         .rx_valid   (valid_o[g]),
         .rx_ready   (ready[g]),
         .rx_level   (lvl_o[g]),
         .rx_ovf     (ovf_o[g]),
         .rx_frm_err (frm_o[g]),
         .clr_flags  (clr_flags),
         .rx_busy    (busy_o[g])
      );
   end

   // Inputs change at posedge+2, so a handshake seen here completes at the next posedge.
   always @(negedge clk) begin
      if (!rst && valid_o[0] && ready[0])
         got_q.push_back(data_o[0]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] v);
      logic [DW-1:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
      for (int i = 0; i < DW; i++)
         r[i] = v[DW-1-i];
`else
      r = v;
`endif
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Master side: shifts v[n-1:0] out MSB first in the given {CPOL,CPHA} mode.
   task automatic send_bits(input logic [31:0] v, input int n, input logic [1:0] mode);
      logic cpol, cpha;
      cpol = mode[1];
      cpha = mode[0];
      for (int i = n - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi = v[i];
            tick(H);
            sck = ~cpol;
            tick(H);
            sck = cpol;
         end else begin
            sck  = ~cpol;
            mosi = v[i];
            tick(H);
            sck = cpol;
            tick(H);
         end
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      tick(H);
   endtask

   task automatic cs_high();
      tick(H);
      cs_n = 1'b1;
      tick(H + 2);
   endtask

   task automatic send_frame(input logic [DW-1:0] v, input logic [1:0] mode);
      cs_low();
      send_bits(32'(v), DW, mode);
      cs_high();
   endtask

   task automatic take_check(input string tag, input logic [DW-1:0] exp);
      logic [DW-1:0] v;
      v = 'x;
      if (got_q.size() != 0)
         v = got_q.pop_front();
      check(tag, 32'(v), 32'(exp));
   endtask

   task automatic pop_check(input string tag, input logic [DW-1:0] exp);
      ready[0] = 1'b1;
      tick(1);
      ready[0] = 1'b0;
      take_check(tag, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; clr_flags = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en[i]    = 1'b0;
         ready[i] = 1'b0;
      end
      tick(3);
      check("rst_data",  32'(data_o[0]), 0);
      check("rst_valid", 32'(valid_o[0]), 0);
      check("rst_level", 32'(lvl_o[0]), 0);
      check("rst_ovf",   32'(ovf_o[0]), 0);
      check("rst_frm",   32'(frm_o[0]), 0);
      check("rst_busy",  32'(busy_o[0]), 0);
      rst = 1'b0;
      tick(2);
      en[0] = 1'b1;

      // Single word, then a non-palindromic word for bit order.
      cs_low();
      check("a5_busy", 32'(busy_o[0]), 1);
      send_bits(32'hA5, DW, 2'b00);
      cs_high();
      check("a5_valid", 32'(valid_o[0]), 1);
      check("a5_data",  32'(data_o[0]), 32'(exp_word(8'hA5)));
      check("a5_level", 32'(lvl_o[0]), 1);
      check("a5_ovf",   32'(ovf_o[0]), 0);
      check("a5_frm",   32'(frm_o[0]), 0);
      check("a5_idle",  32'(busy_o[0]), 0);
      pop_check("a5_pop", exp_word(8'hA5));
      check("a5_empty", 32'(valid_o[0]), 0);
      check("a5_lvl0",  32'(lvl_o[0]), 0);
      send_frame(8'h01, 2'b00);
      check("w01_data", 32'(data_o[0]), 32'(exp_word(8'h01)));
      pop_check("w01_pop", exp_word(8'h01));

      // Back-to-back words in one frame with the consumer always ready.
      got_q.delete();
      ready[0] = 1'b1;
      cs_low();
      send_bits(32'h11, DW, 2'b00);
      check("b2b_busy1", 32'(busy_o[0]), 1);
      send_bits(32'h22, DW, 2'b00);
      send_bits(32'h33, DW, 2'b00);
      check("b2b_busy3", 32'(busy_o[0]), 1);
      cs_high();
      check("b2b_idle", 32'(busy_o[0]), 0);
      ready[0] = 1'b0;
      check("b2b_count", got_q.size(), 3);
      take_check("b2b_w0", exp_word(8'h11));
      take_check("b2b_w1", exp_word(8'h22));
      take_check("b2b_w2", exp_word(8'h33));

      // Overflow: five words into a four-deep FIFO.
      got_q.delete();
      cs_low();
      for (int i = 1; i <= 5; i++)
         send_bits(32'(i * 16), DW, 2'b00);
      cs_high();
      check("ovf_level", 32'(lvl_o[0]), 4);
      check("ovf_flag",  32'(ovf_o[0]), 1);
      check("ovf_frm",   32'(frm_o[0]), 0);
      pop_check("ovf_w1", exp_word(8'h10));
      pop_check("ovf_w2", exp_word(8'h20));
      pop_check("ovf_w3", exp_word(8'h30));
      pop_check("ovf_w4", exp_word(8'h40));
      check("ovf_drained", 32'(lvl_o[0]), 0);
      check("ovf_sticky",  32'(ovf_o[0]), 1);
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      check("ovf_clr", 32'(ovf_o[0]), 0);

      // Frame error on a 5-bit partial word; the following word is intact.
      send_frame(8'h77, 2'b00);
      cs_low();
      send_bits(32'h15, 5, 2'b00);
      cs_high();
      check("frm_flag",  32'(frm_o[0]), 1);
      check("frm_level", 32'(lvl_o[0]), 1);
      send_frame(8'h3C, 2'b00);
      check("frm_level2", 32'(lvl_o[0]), 2);
      pop_check("frm_w0", exp_word(8'h77));
      pop_check("frm_w1", exp_word(8'h3C));
      clr_flags = 1'b1;
      tick(1);
      clr_flags = 1'b0;
      check("frm_clr", 32'(frm_o[0]), 0);

      // Receiver disabled mid-frame: partial word dropped, no error.
      cs_low();
      send_bits(32'h5, 3, 2'b00);
      en[0] = 1'b0;
      tick(1);
      check("dis_busy", 32'(busy_o[0]), 0);
      send_bits(32'h1F, 5, 2'b00);
      cs_high();
      check("dis_level", 32'(lvl_o[0]), 0);
      check("dis_frm",   32'(frm_o[0]), 0);
      check("dis_ovf",   32'(ovf_o[0]), 0);

      // Modes 1..3 on their own instances; instance 0 stays disabled.
      for (int m = 1; m < 4; m++) begin
         sck = (m >= 2);
         tick(4);
         en[m] = 1'b1;
         tick(2);
         send_frame(8'hC3, 2'(m));
         check($sformatf("mode%0d_valid", m), 32'(valid_o[m]), 1);
         check($sformatf("mode%0d_data", m),  32'(data_o[m]), 32'(exp_word(8'hC3)));
         check($sformatf("mode%0d_level", m), 32'(lvl_o[m]), 1);
         check($sformatf("mode%0d_frm", m),   32'(frm_o[m]), 0);
         en[m] = 1'b0;
      end
      sck = 1'b0;
      tick(4);
      check("off_level", 32'(lvl_o[0]), 0);
      check("off_frm",   32'(frm_o[0]), 0);
      en[0] = 1'b1;

      // Asynchronous reset in the middle of a frame with a word buffered.
      send_frame(8'h99, 2'b00);
      check("pre_rst_level", 32'(lvl_o[0]), 1);
      cs_low();
      send_bits(32'h5, 3, 2'b00);
      rst = 1'b1;
      #1;
      check("arst_data",  32'(data_o[0]), 0);
      check("arst_valid", 32'(valid_o[0]), 0);
      check("arst_level", 32'(lvl_o[0]), 0);
      check("arst_busy",  32'(busy_o[0]), 0);
      cs_n = 1'b1;
      sck  = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(3);
      send_frame(8'h5A, 2'b00);
      check("post_rst_data",  32'(data_o[0]), 32'(exp_word(8'h5A)));
      check("post_rst_level", 32'(lvl_o[0]), 1);
      check("post_rst_frm",   32'(frm_o[0]), 0);
      got_q.delete();
      pop_check("post_rst_pop", exp_word(8'h5A));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
